// File: rtl/tdc_therm_if.sv
// Handshake and data bundle between the TDC thermometer encoder and its neighbours.
// master = the side that feeds snapshots and consumes results; slave = the encoder.
interface tdc_therm_if #(
  parameter int TAPS  = 64,
  parameter int OUT_W = 7
);
  logic             start_i;
  logic [TAPS-1:0]  therm_i;
  logic             therm_valid_i;
  logic [OUT_W-1:0] result_o;
  logic             result_valid_o;
  logic             result_ready_i;
  logic             busy_o;
  logic             overflow_o;
  logic             bubble_err_o;
  logic             clear_i;

  modport master (
    output start_i, therm_i, therm_valid_i, result_ready_i, clear_i,
    input  result_o, result_valid_o, busy_o, overflow_o, bubble_err_o
  );

  modport slave (
    input  start_i, therm_i, therm_valid_i, result_ready_i, clear_i,
    output result_o, result_valid_o, busy_o, overflow_o, bubble_err_o
  );
endinterface

// File: rtl/tdc_therm_encoder.sv
// TDC thermometer encoder: snapshot capture, 3-tap majority bubble correction,
// first-zero encoding, averaging of 2**AVG_LOG2 codes and valid/ready result hand-off.
module tdc_therm_encoder #(
  parameter int TAPS     = 64,
  parameter int OUT_W    = 7,
  parameter int AVG_LOG2 = 2
) (
  input  logic          clk,
  input  logic          rst,
  tdc_therm_if.slave    bus
);
  localparam int N     = 1 << AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int ACC_W = OUT_W + AVG_LOG2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic                busy_nxt_s;
  logic                valid_nxt_s;
  logic                busy_r;
  logic                result_valid_r;

  logic                start_s;
  logic                accept_s;
  logic                last_s;
  logic [TAPS-1:0]     snap_r;
  logic                snap_vld_r;
  logic [CNT_W-1:0]    in_cnt_r;

  logic [TAPS+1:0]     ext_s;
  logic [TAPS-1:0]     maj_s;
  logic [OUT_W-1:0]    code_s;
  logic                bubble_s;
  logic                found_s;
  logic [OUT_W-1:0]    code_r;
  logic                code_vld_r;

  logic [ACC_W-1:0]    acc_r;
  logic [ACC_W-1:0]    sum_s;
  logic [CNT_W-1:0]    acc_cnt_r;
  logic [OUT_W-1:0]    result_r;
  logic                overflow_r;
  logic                bubble_err_r;

  // 3-input majority vote used by the bubble corrector.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign start_s  = (state_r == IDLE) && bus.start_i;
  assign accept_s = bus.therm_valid_i && (state_r == ACCUM) && (in_cnt_r < CNT_W'(N));
  assign last_s   = code_vld_r && (state_r == ACCUM) && (acc_cnt_r == CNT_W'(N - 1));
  assign sum_s    = acc_r + ACC_W'(code_r);

  // State register plus registered handshake/busy outputs decoded from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      busy_r         <= 1'b0;
      result_valid_r <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      busy_r         <= busy_nxt_s;
      result_valid_r <= valid_nxt_s;
    end
  end

  // Next-state logic: start only from IDLE, DONE after the N-th code, IDLE on transfer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start_i) state_nxt_s = ACCUM;
        else             state_nxt_s = IDLE;
      end
      ACCUM: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = ACCUM;
      end
      DONE: begin
        if (bus.result_ready_i) state_nxt_s = IDLE;
        else                    state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode of the upcoming state so busy/valid come straight from flops.
  always_comb begin
    busy_nxt_s  = 1'b0;
    valid_nxt_s = 1'b0;
    case (state_nxt_s)
      IDLE:    begin busy_nxt_s = 1'b0; valid_nxt_s = 1'b0; end
      ACCUM:   begin busy_nxt_s = 1'b1; valid_nxt_s = 1'b0; end
      DONE:    begin busy_nxt_s = 1'b1; valid_nxt_s = 1'b1; end
      default: begin busy_nxt_s = 1'b0; valid_nxt_s = 1'b0; end
    endcase
  end

  // Stage 1: capture accepted snapshots and count them against the per-measurement budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_r     <= {TAPS{1'b0}};
      snap_vld_r <= 1'b0;
      in_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      snap_vld_r <= accept_s;
      if (accept_s) begin
        snap_r   <= bus.therm_i;
        in_cnt_r <= in_cnt_r + CNT_W'(1);
      end else if (start_s) begin
        in_cnt_r <= {CNT_W{1'b0}};
      end else begin
        in_cnt_r <= in_cnt_r;
      end
    end
  end

  // Majority-corrected vector; the line is padded with a 1 below tap 0 and a 0 above the top tap.
  always_comb begin
    ext_s = {1'b0, snap_r, 1'b1};
    maj_s = {TAPS{1'b0}};
    for (int i = 0; i < TAPS; i++) begin
      maj_s[i] = maj3(ext_s[i], ext_s[i+1], ext_s[i+2]);
    end
  end

  // Encoder: first zero gives the code; any one above it marks a residual bubble.
  always_comb begin
    code_s   = OUT_W'(TAPS);
    bubble_s = 1'b0;
    found_s  = 1'b0;
    for (int i = 0; i < TAPS; i++) begin
      if (found_s) begin
        bubble_s = bubble_s | maj_s[i];
      end else if (!maj_s[i]) begin
        code_s  = OUT_W'(i);
        found_s = 1'b1;
      end else begin
        found_s = 1'b0;
      end
    end
  end

  // Stage 2: register the code for the accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_r     <= {OUT_W{1'b0}};
      code_vld_r <= 1'b0;
    end else begin
      code_vld_r <= snap_vld_r;
      if (snap_vld_r) code_r <= code_s;
      else            code_r <= code_r;
    end
  end

  // Sticky flags: a set event in the same cycle as clear_i keeps the flag high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r   <= 1'b0;
      bubble_err_r <= 1'b0;
    end else begin
      if (snap_vld_r && (code_s == OUT_W'(TAPS))) overflow_r <= 1'b1;
      else if (bus.clear_i)                       overflow_r <= 1'b0;
      else                                        overflow_r <= overflow_r;
      if (snap_vld_r && bubble_s) bubble_err_r <= 1'b1;
      else if (bus.clear_i)       bubble_err_r <= 1'b0;
      else                        bubble_err_r <= bubble_err_r;
    end
  end

  // Stage 3: accumulate codes; the N-th code produces the truncated average.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r     <= {ACC_W{1'b0}};
      acc_cnt_r <= {CNT_W{1'b0}};
      result_r  <= {OUT_W{1'b0}};
    end else begin
      if (start_s) begin
        acc_r     <= {ACC_W{1'b0}};
        acc_cnt_r <= {CNT_W{1'b0}};
      end else if (code_vld_r && (state_r == ACCUM)) begin
        acc_r     <= sum_s;
        acc_cnt_r <= acc_cnt_r + CNT_W'(1);
      end else begin
        acc_r     <= acc_r;
        acc_cnt_r <= acc_cnt_r;
      end
      if (last_s) result_r <= sum_s[ACC_W-1:AVG_LOG2];
      else        result_r <= result_r;
    end
  end

  assign bus.result_o       = result_r;
  assign bus.result_valid_o = result_valid_r;
  assign bus.busy_o         = busy_r;
  assign bus.overflow_o     = overflow_r;
  assign bus.bubble_err_o   = bubble_err_r;
endmodule

// File: tb/tb_tdc_therm_encoder.sv
// Directed self-checking bench for tdc_therm_encoder (TAPS=64, OUT_W=7, AVG_LOG2=2).
`timescale 1ns/1ps
module tb_tdc_therm_encoder;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  tdc_therm_if #(.TAPS(64), .OUT_W(7)) bus ();

  tdc_therm_encoder #(.TAPS(64), .OUT_W(7), .AVG_LOG2(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] th(input int n);
    logic [63:0] one;
    one = 64'd1;
    if (n >= 64) return {64{1'b1}};
    else         return (one << n) - 64'd1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
  endtask

  task automatic sample(input logic [63:0] v);
    bus.therm_i       = v;
    bus.therm_valid_i = 1'b1;
    tick();
    bus.therm_valid_i = 1'b0;
  endtask

  // Four back-to-back samples, then check valid arrives exactly in cycle c+3.
  task automatic run4(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                      input logic [63:0] d, input int exp, input string tag);
    start_pulse();
    sample(a); sample(b); sample(c); sample(d);
    check_eq({tag, "_valid_c1"}, 32'(bus.result_valid_o), 32'd0);
    tick();
    check_eq({tag, "_valid_c2"}, 32'(bus.result_valid_o), 32'd0);
    tick();
    check_eq({tag, "_valid_c3"}, 32'(bus.result_valid_o), 32'd1);
    check_eq({tag, "_result"}, 32'(bus.result_o), 32'(exp));
  endtask

  task automatic accept(input string tag);
    bus.result_ready_i = 1'b1;
    tick();
    bus.result_ready_i = 1'b0;
    check_eq({tag, "_valid_after"}, 32'(bus.result_valid_o), 32'd0);
    check_eq({tag, "_busy_after"}, 32'(bus.busy_o), 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!bus.result_valid_o && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_valid_seen"}, 32'(bus.result_valid_o), 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.therm_i = 64'd0;
    bus.therm_valid_i = 1'b0;
    bus.result_ready_i = 1'b0;
    bus.clear_i = 1'b0;
    #12;
    check_eq("rst_busy", 32'(bus.busy_o), 32'd0);
    check_eq("rst_valid", 32'(bus.result_valid_o), 32'd0);
    check_eq("rst_result", 32'(bus.result_o), 32'd0);
    check_eq("rst_ovf", 32'(bus.overflow_o), 32'd0);
    check_eq("rst_bub", 32'(bus.bubble_err_o), 32'd0);
    rst = 1'b0;
    tick();

    // 1: reset in the middle of an accumulation (samples overflow so a flag is set first)
    start_pulse();
    sample(th(64));
    sample(th(64));
    check_eq("t1_busy_pre", 32'(bus.busy_o), 32'd1);
    check_eq("t1_ovf_pre", 32'(bus.overflow_o), 32'd1);
    #2 rst = 1'b1;
    #2;
    check_eq("t1_busy_async", 32'(bus.busy_o), 32'd0);
    check_eq("t1_valid_async", 32'(bus.result_valid_o), 32'd0);
    check_eq("t1_ovf_async", 32'(bus.overflow_o), 32'd0);
    check_eq("t1_bub_async", 32'(bus.bubble_err_o), 32'd0);
    #2 rst = 1'b0;
    tick();
    run4(th(10), th(12), th(14), th(16), 13, "t1_fresh");
    accept("t1_fresh");

    // 2: averaging, including truncation of the fractional part
    run4(th(10), th(12), th(14), th(16), 13, "t2_avg13");
    check_eq("t2_busy_done", 32'(bus.busy_o), 32'd1);
    accept("t2_avg13");
    check_eq("t2_result_kept", 32'(bus.result_o), 32'd13);
    run4(th(0), th(1), th(2), th(3), 1, "t2_trunc");
    accept("t2_trunc");

    // 3: bubble correction
    run4(64'h1B, 64'h1B, 64'h1B, 64'h1B, 5, "t3_fix");
    check_eq("t3_fix_bub", 32'(bus.bubble_err_o), 32'd0);
    accept("t3_fix");
    run4(64'h30F, 64'h30F, 64'h30F, 64'h30F, 4, "t3_bub");
    check_eq("t3_bub_flag", 32'(bus.bubble_err_o), 32'd1);
    accept("t3_bub");
    check_eq("t3_bub_sticky", 32'(bus.bubble_err_o), 32'd1);
    bus.clear_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
    check_eq("t3_bub_clr", 32'(bus.bubble_err_o), 32'd0);

    // 4: overflow flag, clear, and set-wins-over-clear
    run4(th(64), th(64), th(64), th(64), 64, "t4_ovf");
    check_eq("t4_ovf_flag", 32'(bus.overflow_o), 32'd1);
    accept("t4_ovf");
    check_eq("t4_ovf_sticky", 32'(bus.overflow_o), 32'd1);
    bus.clear_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
    check_eq("t4_ovf_clr", 32'(bus.overflow_o), 32'd0);
    start_pulse();
    sample(th(64));
    bus.clear_i = 1'b1;
    sample(th(64));
    bus.clear_i = 1'b0;
    check_eq("t4_set_wins", 32'(bus.overflow_o), 32'd1);
    sample(th(64));
    sample(th(64));
    wait_valid("t4_b");
    check_eq("t4_b_result", 32'(bus.result_o), 32'd64);
    accept("t4_b");
    bus.clear_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
    check_eq("t4_ovf_clr2", 32'(bus.overflow_o), 32'd0);

    // 5: backpressure with stray snapshots and start pulses
    run4(th(20), th(22), th(24), th(26), 23, "t5");
    for (int k = 0; k < 10; k++) begin
      bus.therm_i = th(64);
      bus.therm_valid_i = 1'b1;
      bus.start_i = k[0];
      tick();
      check_eq("t5_hold_valid", 32'(bus.result_valid_o), 32'd1);
      check_eq("t5_hold_result", 32'(bus.result_o), 32'd23);
    end
    bus.therm_valid_i = 1'b0;
    bus.start_i = 1'b0;
    check_eq("t5_no_extra", 32'(bus.overflow_o), 32'd0);
    accept("t5");
    run4(th(30), th(31), th(32), th(33), 31, "t5_next");
    accept("t5_next");

    // 6: sample gating in IDLE and beyond N per measurement
    bus.therm_i = th(64);
    bus.therm_valid_i = 1'b1;
    tick(); tick(); tick();
    bus.therm_valid_i = 1'b0;
    check_eq("t6_idle_ovf", 32'(bus.overflow_o), 32'd0);
    check_eq("t6_idle_busy", 32'(bus.busy_o), 32'd0);
    start_pulse();
    sample(th(8)); sample(th(8)); sample(th(8)); sample(th(8));
    sample(th(64)); sample(th(64));
    wait_valid("t6");
    check_eq("t6_result", 32'(bus.result_o), 32'd8);
    check_eq("t6_ovf", 32'(bus.overflow_o), 32'd0);
    accept("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
